// File: rtl/ex_stage_muldiv.sv
// ex_stage_muldiv: MIPS execute stage with forwarding ALU and iterative mul/div unit with HI/LO.
module ex_stage_muldiv #(
    parameter int W        = 32,
    parameter int RA       = 5,
    parameter int LINK_REG = 31,
    parameter int EXC_REG  = 26
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [W-1:0]  rs_data,
    input  logic [W-1:0]  rt_data,
    input  logic [W-1:0]  imm,
    input  logic [RA-1:0] rs_addr,
    input  logic [RA-1:0] rt_addr,
    input  logic [RA-1:0] rd_addr,
    input  logic [4:0]    shamt,
    input  logic          alu_src,
    input  logic [1:0]    reg_dst,
    input  logic [3:0]    alu_op,
    input  logic [3:0]    md_op,
    input  logic [W-1:0]  mem_fwd_data,
    input  logic [RA-1:0] mem_fwd_addr,
    input  logic          mem_fwd_we,
    input  logic [W-1:0]  wb_fwd_data,
    input  logic [RA-1:0] wb_fwd_addr,
    input  logic          wb_fwd_we,
    output logic [W-1:0]  alu_out,
    output logic          zero,
    output logic [W-1:0]  mem_wdata,
    output logic [RA-1:0] wr_addr,
    output logic          md_busy,
    output logic          stall,
    output logic          out_valid
);
    localparam int CW = $clog2(W);
    typedef enum logic [1:0] {IDLE, RUN, FIN} stateT;
    stateT state, nextState;
    logic [W-1:0] fwdA, fwdB, opB, aluRes, hi, lo, magA, magB;
    logic [2*W-1:0] acc, product;
    logic [CW-1:0] cnt;
    logic [W:0] mulSum, trial, diff;
    logic sgnA, sgnB, isDiv, isSigned, divZero, isMd, mdStart, opSigned;
    assign fwdA = (mem_fwd_we && mem_fwd_addr == rs_addr && mem_fwd_addr != '0) ? mem_fwd_data :
                  (wb_fwd_we && wb_fwd_addr == rs_addr && wb_fwd_addr != '0) ? wb_fwd_data : rs_data;
    assign fwdB = (mem_fwd_we && mem_fwd_addr == rt_addr && mem_fwd_addr != '0) ? mem_fwd_data :
                  (wb_fwd_we && wb_fwd_addr == rt_addr && wb_fwd_addr != '0) ? wb_fwd_data : rt_data;
    assign opB = alu_src ? imm : fwdB;
    assign zero = fwdA == fwdB;
    assign mem_wdata = fwdB;
    assign wr_addr = reg_dst == 2'b00 ? rt_addr : reg_dst == 2'b01 ? rd_addr :
                     reg_dst == 2'b10 ? RA'(LINK_REG) : RA'(EXC_REG);
    always_comb begin
        aluRes = '0;
        case (alu_op)
            4'd0:    aluRes = fwdA + opB;
            4'd1:    aluRes = fwdA - opB;
            4'd2:    aluRes = fwdA & opB;
            4'd3:    aluRes = fwdA | opB;
            4'd4:    aluRes = fwdA ^ opB;
            4'd5:    aluRes = ~(fwdA | opB);
            4'd6:    aluRes = W'($signed(fwdA) < $signed(opB));
            4'd7:    aluRes = W'(fwdA < opB);
            4'd8:    aluRes = opB << shamt;
            4'd9:    aluRes = opB >> shamt;
            4'd10:   aluRes = W'($signed(opB) >>> shamt);
            4'd11:   aluRes = opB << (W / 2);
            4'd12:   aluRes = opB << fwdA[4:0];
            4'd13:   aluRes = opB >> fwdA[4:0];
            4'd14:   aluRes = W'($signed(opB) >>> fwdA[4:0]);
            default: aluRes = fwdA;
        endcase
    end
    assign alu_out = md_op == 4'd5 ? hi : md_op == 4'd6 ? lo : aluRes;
    assign isMd = md_op >= 4'd1 && md_op <= 4'd8;
    assign md_busy = state != IDLE && !reset;
    assign stall = in_valid && md_busy && isMd;
    assign out_valid = in_valid && !stall && !reset;
    assign mdStart = in_valid && !stall && md_op >= 4'd1 && md_op <= 4'd4;
    assign opSigned = md_op == 4'd1 || md_op == 4'd3;
    // Multiply: shift-add into the high half; divide: restoring, quotient bits shift into the low half.
    assign mulSum = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, magA} : '0);
    assign trial = acc[2*W-1:W-1];
    assign diff = trial - {1'b0, magB};
    assign product = (isSigned && (sgnA ^ sgnB)) ? -acc : acc;
    always_comb nextState = state == IDLE ? (mdStart ? RUN : IDLE) :
                            state == RUN ? (cnt == '0 ? FIN : RUN) : IDLE;
    always_ff @(posedge clk)
        if (reset) state <= IDLE;
        else state <= nextState;
    always_ff @(posedge clk) begin
        if (reset) begin
            hi <= '0;
            lo <= '0;
            cnt <= '0;
            acc <= '0;
            magA <= '0;
            magB <= '0;
            sgnA <= 1'b0;
            sgnB <= 1'b0;
            isDiv <= 1'b0;
            isSigned <= 1'b0;
            divZero <= 1'b0;
        end else if (mdStart) begin
            sgnA <= opSigned && fwdA[W-1];
            sgnB <= opSigned && fwdB[W-1];
            magA <= (opSigned && fwdA[W-1]) ? -fwdA : fwdA;
            magB <= (opSigned && fwdB[W-1]) ? -fwdB : fwdB;
            isDiv <= md_op == 4'd3 || md_op == 4'd4;
            isSigned <= opSigned;
            divZero <= fwdB == '0;
            acc <= {{W{1'b0}}, (md_op == 4'd3 || md_op == 4'd4) ? ((opSigned && fwdA[W-1]) ? -fwdA : fwdA)
                                                                  : ((opSigned && fwdB[W-1]) ? -fwdB : fwdB)};
            cnt <= CW'(W - 1);
        end else if (state == RUN) begin
            acc <= isDiv ? {diff[W] ? trial[W-1:0] : diff[W-1:0], acc[W-2:0], ~diff[W]} : {mulSum, acc[W-1:1]};
            cnt <= cnt - 1'b1;
        end else if (state == FIN) begin
            hi <= !isDiv ? product[2*W-1:W] : divZero ? (sgnA ? -magA : magA) :
                  (isSigned && sgnA) ? -acc[2*W-1:W] : acc[2*W-1:W];
            lo <= !isDiv ? product[W-1:0] : divZero ? '1 :
                  (isSigned && (sgnA ^ sgnB)) ? -acc[W-1:0] : acc[W-1:0];
        end else if (in_valid && !stall) begin
            if (md_op == 4'd7) hi <= fwdA;
            if (md_op == 4'd8) lo <= fwdA;
        end
    end
endmodule

// File: doc/ex_stage_muldiv.md
Name: ex_stage_muldiv

Overview:
- Parametrised next-generation execute stage for the 5-stage MIPS pipeline.
- Keeps the existing combinational ALU path with MEM/WB operand forwarding and destination-register select.
- Adds an iterative multiply/divide unit with HI/LO registers and MFHI/MFLO/MTHI/MTLO support.
- Adds a stall output that holds the front of the pipeline while a HI/LO consumer waits on a running operation.

Parameters:
- W, 32: datapath width in bits (even, >=8).
- RA, 5: register address width.
- LINK_REG, 31: destination when reg_dst=2'b10.
- EXC_REG, 26: destination when reg_dst=2'b11.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- in_valid  in  1  EX holds a valid instruction
- rs_data  in  W  register-file rs value
- rt_data  in  W  register-file rt value
- imm  in  W  extended immediate
- rs_addr  in  RA  rs index
- rt_addr  in  RA  rt index
- rd_addr  in  RA  rd index
- shamt  in  5  shift amount
- alu_src  in  1  1: operand B = imm; 0: operand B = forwarded rt
- reg_dst  in  2  00 rt, 01 rd, 10 LINK_REG, 11 EXC_REG
- alu_op  in  4  ALU operation (see Behaviour)
- md_op  in  4  mul/div operation (see Behaviour)
- mem_fwd_data  in  W  MEM-stage result
- mem_fwd_addr  in  RA  MEM-stage destination
- mem_fwd_we  in  1  MEM-stage register write enable
- wb_fwd_data  in  W  WB-stage result
- wb_fwd_addr  in  RA  WB-stage destination
- wb_fwd_we  in  1  WB-stage register write enable
- alu_out  out  W  result
- zero  out  1  operand A == operand B (forwarded values, before the alu_src mux)
- mem_wdata  out  W  forwarded rt, for stores
- wr_addr  out  RA  selected destination register
- md_busy  out  1  mul/div unit running
- stall  out  1  freeze IF/ID/EX this cycle
- out_valid  out  1  in_valid & ~stall & ~reset

Behaviour:
- Forwarding, per operand:
  - MEM match (mem_fwd_we, addr==src, addr!=0) has priority over a WB match.
  - Otherwise use the register-file value.
  - Index 0 is never forwarded.
- ALU ops:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT signed, 7 SLTU.
  - 8 SLL by shamt, 9 SRL by shamt, 10 SRA by shamt.
  - 11 LUI: B << (W/2).
  - 12 SLLV, 13 SRLV, 14 SRAV: shift B by A[4:0].
  - 15 PASS A.
  - All arithmetic wraps modulo 2^W; no overflow trap.
- md_op codes: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO, 9-15 treated as NONE.
- stall = in_valid & md_busy & (md_op in 1..8). This is combinational; no other stall source exists.
- md FSM states IDLE, RUN, FIN:
  - IDLE -> RUN when in_valid & ~stall & md_op in 1..4.
  - On that edge, latch the forwarded A/B magnitudes and signs (signed ops take absolute value), clear HI/LO accumulators, load counter = W-1.
  - The issuing instruction leaves EX normally (out_valid=1); it does not stall itself.
  - RUN: one shift-add (multiply) or restoring-subtract (divide) step per cycle, counter decrements; at counter 0 -> FIN.
  - FIN: apply sign fix-up and write HI/LO; -> IDLE.
  - md_busy = (state != IDLE). Latency: op accepted at edge T; HI/LO visible in the cycle after edge T+W+1. Busy duration is exactly W+1 cycles.
- Results:
  - MULT/MULTU: {HI,LO} = 2W-bit product.
  - DIV/DIVU: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - Divide by zero: LO = all ones, HI = dividend (unsigned pattern, no fix-up). No exception.
  - Signed DIV of most-negative by -1: LO = most-negative, HI = 0.
- MFHI/MFLO: alu_out = HI/LO when not stalled; alu_op ignored.
- MTHI/MTLO: write the forwarded A into HI/LO at the edge when in_valid & ~stall.
- While md_op != NONE, alu_out carries the md result (MFHI/MFLO) or the ALU result (all other md ops, don't-care to the pipeline).
- reset:
  - HI=LO=0, state IDLE, counter 0; md_busy=0, stall=0, out_valid=0 while reset is high.
  - Reset during RUN aborts the operation; HI/LO keep their reset value of 0.
  - Combinational outputs follow inputs.
- Simultaneous events:
  - MTHI while IDLE with an md op issuing the same cycle cannot occur (single issue).
  - A stalled instruction re-presents unchanged and completes in the cycle after md_busy falls.

Test Plan:
- Forward priority: rs_addr=3, mem_fwd(3,we=1,0x10), wb_fwd(3,we=1,0x20), rs_data=0x30, ADD with imm=1, alu_src=1 -> alu_out=0x11. Repeat with mem_fwd_we=0 -> 0x21. Repeat with addr 0 on both stages -> 0x31.
- Reg select/ALU: reg_dst 00/01/10/11 with rt=5, rd=7 -> wr_addr 5, 7, 31, 26. SRA A=x, B=0x80000000, shamt=4 -> 0xF8000000. SLT -1 vs 1 -> 1; SLTU -> 0.
- MULT -3*5 issued at edge T, MFHI presented at T+1 -> stall=1 for cycles T+1..T+W+1, then alu_out=0xFFFFFFFF; next MFLO -> 0xFFFFFFF1.
- DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/0 -> LO=0xFFFFFFFF, HI=7. DIV 0x80000000/-1 -> LO=0x80000000, HI=0.
- Reset asserted mid-RUN at cycle T+5 -> next cycle md_busy=0, MFHI returns 0, no stall.
- MTLO 0x1234 while idle, MFLO next cycle -> 0x1234; MTLO while busy -> stalled until md_busy falls, then written, overriding the multiply's LO.
